// File: rtl/fifo_watermark_monitor.sv
// fifo_watermark_monitor
//
// Tracks the occupancy of four independent FIFOs from their push/pop strobes
// and raises per-FIFO almost-full (pause) flags, a one-cycle release pulse
// when a pause clears, and sticky overflow flags. Thresholds are loaded with
// init; an invalid pair returns the block to IDLE and raises cfg_err.
//
// Optional feature: define WM_HYSTERESIS_EN so that a pause clears only once
// the occupancy has drained to umbral_bajo. Without it, a pause clears as soon
// as the occupancy drops below umbral_alto.
//
// Parameters
//   DEPTH        entries per monitored FIFO
//   CW           occupancy/threshold width, must hold 0..DEPTH
// Ports
//   clk          rising-edge clock
//   reset_L      asynchronous active-low reset
//   init         threshold-load request
//   umbral_alto  almost-full threshold, sampled while init is high
//   umbral_bajo  almost-empty threshold, sampled while init is high
//   push, pop    per-FIFO write / read strobes
//   pause        per-FIFO almost-full flag (registered)
//   continue_p   per-FIFO pulse, high in the first cycle pause is low again
//   error_full   per-FIFO sticky overflow flag (registered)
//   FIFOpause    OR of pause
//   FIFOcontinue OR of continue_p
//   idle         high while in IDLE
//   cfg_err      last init carried invalid thresholds
module fifo_watermark_monitor #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          init,
  input  logic [CW-1:0] umbral_alto,
  input  logic [CW-1:0] umbral_bajo,
  input  logic [3:0]    push,
  input  logic [3:0]    pop,
  output logic [3:0]    pause,
  output logic [3:0]    continue_p,
  output logic [3:0]    error_full,
  output logic          FIFOpause,
  output logic          FIFOcontinue,
  output logic          idle,
  output logic          cfg_err
);

  localparam int NCH = 4;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t        state_q;
  logic [CW-1:0] alto_q;
`ifdef WM_HYSTERESIS_EN
  logic [CW-1:0] bajo_q;
`endif
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];
  logic [NCH-1:0] ovf_d;
  logic [NCH-1:0] pause_d;
  logic           cfg_ok;

  // Saturating up/down step: push+pop together leaves the count unchanged,
  // a push at DEPTH holds at DEPTH, a pop at zero holds at zero.
  function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] cnt,
                                             input logic          inc,
                                             input logic          dec);
    logic [CW-1:0] res;
    res = cnt;
    if (inc && !dec && cnt != DEPTH_C) res = cnt + CW'(1);
    else if (dec && !inc && cnt != '0) res = cnt - CW'(1);
    return res;
  endfunction

  function automatic logic overflow(input logic [CW-1:0] cnt,
                                    input logic          inc,
                                    input logic          dec);
    return inc && !dec && (cnt == DEPTH_C);
  endfunction

  assign cfg_ok = (umbral_bajo < umbral_alto) && (umbral_alto <= DEPTH_C);

  // Next-count and next-pause per channel, evaluated against the current
  // thresholds so pause moves on the same edge as the counter.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = sat_step(cnt_q[i], push[i], pop[i]);
      ovf_d[i] = overflow(cnt_q[i], push[i], pop[i]);
`ifdef WM_HYSTERESIS_EN
      if (cnt_d[i] >= alto_q)      pause_d[i] = 1'b1;
      else if (cnt_d[i] <= bajo_q) pause_d[i] = 1'b0;
      else                         pause_d[i] = pause[i];
`else
      pause_d[i] = (cnt_d[i] >= alto_q);
`endif
    end
  end

  // State / counter / flag register stage
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      alto_q     <= '0;
`ifdef WM_HYSTERESIS_EN
      bajo_q     <= '0;
`endif
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      pause      <= '0;
      continue_p <= '0;
      error_full <= '0;
      idle       <= 1'b1;
      cfg_err    <= 1'b0;
    end else if (init) begin
      // Strobes are ignored on an init cycle; a release pulse never spans it.
      continue_p <= '0;
      if (cfg_ok) begin
        state_q <= ACTIVE;
        alto_q  <= umbral_alto;
`ifdef WM_HYSTERESIS_EN
        bajo_q  <= umbral_bajo;
`endif
        idle    <= 1'b0;
        cfg_err <= 1'b0;
      end else begin
        // A rejected configuration wipes the old thresholds and all
        // occupancy so nothing stale survives into the next valid init.
        state_q    <= IDLE;
        alto_q     <= '0;
`ifdef WM_HYSTERESIS_EN
        bajo_q     <= '0;
`endif
        for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        pause      <= '0;
        error_full <= '0;
        idle       <= 1'b1;
        cfg_err    <= 1'b1;
      end
    end else if (state_q == ACTIVE) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      pause      <= pause_d;
      // Pulse coincides with the first cycle in which pause reads low.
      continue_p <= pause & ~pause_d;
      error_full <= error_full | ovf_d;
    end
  end

  assign FIFOpause    = |pause;
  assign FIFOcontinue = |continue_p;

endmodule

// File: tb/tb_fifo_watermark_monitor.sv
// Directed, table-driven bench for fifo_watermark_monitor (DEPTH=8, CW=4).
// Thresholds used throughout: alto=6, bajo=2. Expectations follow the
// WM_HYSTERESIS_EN setting the bench is compiled with.
module tb_fifo_watermark_monitor;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       init;
  logic [3:0] umbral_alto, umbral_bajo;
  logic [3:0] push, pop;
  logic [3:0] pause, continue_p, error_full;
  logic       FIFOpause, FIFOcontinue, idle, cfg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_watermark_monitor #(.DEPTH(8), .CW(4)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .init         (init),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .push         (push),
    .pop          (pop),
    .pause        (pause),
    .continue_p   (continue_p),
    .error_full   (error_full),
    .FIFOpause    (FIFOpause),
    .FIFOcontinue (FIFOcontinue),
    .idle         (idle),
    .cfg_err      (cfg_err)
  );

  typedef struct {
    logic       init;
    logic [3:0] alto;
    logic [3:0] bajo;
    logic [3:0] push;
    logic [3:0] pop;
    logic [3:0] e_pause;
    logic [3:0] e_cont;
    logic [3:0] e_err;
    logic       e_idle;
    logic       e_cfg;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic i, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] pu, input logic [3:0] po,
                     input logic [3:0] ep, input logic [3:0] ec,
                     input logic [3:0] ee, input logic ei, input logic eg);
    vec_t v;
    v.init = i; v.alto = a; v.bajo = b; v.push = pu; v.pop = po;
    v.e_pause = ep; v.e_cont = ec; v.e_err = ee; v.e_idle = ei; v.e_cfg = eg;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, sample 1 time unit after
  // the following rising edge.
  task automatic step(input logic i, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] pu, input logic [3:0] po);
    @(negedge clk);
    init = i; umbral_alto = a; umbral_bajo = b; push = pu; pop = po;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] base;
    reset_L = 1'b0;
    init = 1'b0; umbral_alto = '0; umbral_bajo = '0; push = '0; pop = '0;

    // ---- build vector table ----
    add(0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0);   // pushes ignored in IDLE
    add(0, 0, 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1, 0);
    add(1, 6, 2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);   // valid init
    for (int k = 1; k <= 6; k++)                          // FIFO0 to 6
      add(0, 0, 0, 4'h1, 4'h0, (k == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0, 0, 0);
`ifdef WM_HYSTERESIS_EN
    add(0, 0, 0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 0, 0);   // 5
    add(0, 0, 0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 0, 0);   // 4
    add(0, 0, 0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 0, 0);   // 3
    add(0, 0, 0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 0, 0);   // 2: release
    base = 4'h4;
`else
    add(0, 0, 0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 0, 0);   // 5: release
    add(0, 0, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0);   // 4
    add(0, 0, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0);   // 3
    add(0, 0, 0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0);   // 2
    base = 4'h0;
`endif
    add(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);   // pulse gone
    for (int k = 1; k <= 8; k++)                          // FIFO2 to 8
      add(0, 0, 0, 4'h4, 4'h0, (k >= 6) ? 4'h4 : 4'h0, 4'h0, 4'h0, 0, 0);
    add(0, 0, 0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 0, 0);   // overflow
    add(0, 0, 0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h4, 0, 0);   // 7, sticky
    add(0, 0, 0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h4, 0, 0);   // 6
    add(0, 0, 0, 4'h0, 4'h4, base, 4'h4 & ~base, 4'h4, 0, 0); // 5
    for (int k = 1; k <= 8; k++)                          // FIFO1 to 8
      add(0, 0, 0, 4'h2, 4'h0, base | ((k >= 6) ? 4'h2 : 4'h0), 4'h0, 4'h4, 0, 0);
    // push+pop on FIFO1 at 8 and FIFO3 at 0: no change, no error
    add(0, 0, 0, 4'hA, 4'hA, base | 4'h2, 4'h0, 4'h4, 0, 0);
    add(0, 0, 0, 4'h0, 4'h8, base | 4'h2, 4'h0, 4'h4, 0, 0); // pop at 0
    for (int k = 1; k <= 6; k++)                          // FIFO3 to 6
      add(0, 0, 0, 4'h8, 4'h0, base | 4'h2 | ((k == 6) ? 4'h8 : 4'h0), 4'h0, 4'h4, 0, 0);
    // pop on all four at once: counts 1,7,4,5
`ifdef WM_HYSTERESIS_EN
    add(0, 0, 0, 4'h0, 4'hF, 4'hE, 4'h0, 4'h4, 0, 0);
`else
    add(0, 0, 0, 4'h0, 4'hF, 4'h2, 4'h8, 4'h4, 0, 0);
`endif
    add(1, 3, 5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1);   // invalid init
    add(0, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1);
    add(1, 9, 2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1);   // alto > DEPTH
    add(1, 6, 2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);   // valid again
    for (int k = 1; k <= 6; k++)                          // counters were cleared
      add(0, 0, 0, 4'h1, 4'h0, (k == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0, 0, 0);

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("reset_idle", -1, {3'b0, idle}, 4'h1);
    chk("reset_pause", -1, pause, 4'h0);
    chk("reset_err", -1, error_full, 4'h0);
    chk("reset_cfg", -1, {3'b0, cfg_err}, 4'h0);
    @(negedge clk);
    reset_L = 1'b1;

    // ---- table ----
    for (int n = 0; n < tbl.size(); n++) begin
      step(tbl[n].init, tbl[n].alto, tbl[n].bajo, tbl[n].push, tbl[n].pop);
      chk("pause", n, pause, tbl[n].e_pause);
      chk("continue_p", n, continue_p, tbl[n].e_cont);
      chk("error_full", n, error_full, tbl[n].e_err);
      chk("FIFOpause", n, {3'b0, FIFOpause}, {3'b0, |tbl[n].e_pause});
      chk("FIFOcontinue", n, {3'b0, FIFOcontinue}, {3'b0, |tbl[n].e_cont});
      chk("idle", n, {3'b0, idle}, {3'b0, tbl[n].e_idle});
      chk("cfg_err", n, {3'b0, cfg_err}, {3'b0, tbl[n].e_cfg});
    end

    // ---- overflow on FIFO2 survives pops, cleared only by async reset ----
    for (int k = 0; k < 9; k++) step(0, 0, 0, 4'h4, 4'h0);
    chk("ovf_set", 100, error_full, 4'h4);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 4'h0, 4'h4);
    chk("ovf_held", 101, error_full, 4'h4);
    @(negedge clk);
    init = 1'b0; push = '0; pop = '0;
    #2 reset_L = 1'b0;
    #1;  // still before the next rising edge
    chk("async_err", 102, error_full, 4'h0);
    chk("async_pause", 102, pause, 4'h0);
    chk("async_idle", 102, {3'b0, idle}, 4'h1);
    chk("async_FIFOpause", 102, {3'b0, FIFOpause}, 4'h0);
    @(negedge clk);
    reset_L = 1'b1;
    step(0, 0, 0, 4'hF, 4'h0);
    step(0, 0, 0, 4'hF, 4'h0);
    chk("post_reset_idle", 103, {3'b0, idle}, 4'h1);
    chk("post_reset_pause", 103, pause, 4'h0);
    step(1, 6, 2, 4'h0, 4'h0);
    chk("reinit_idle", 104, {3'b0, idle}, 4'h0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 4'h4, 4'h0);
    chk("reinit_5", 105, pause, 4'h0);
    step(0, 0, 0, 4'h4, 4'h0);
    chk("reinit_6", 106, pause, 4'h4);
    chk("reinit_err", 106, error_full, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
